// File: rtl/motor_step_generator_pkg.sv
// Shared types and default timing constants for the
// per-motor step/direction pulse generator.
package MCPkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } stepgen_state_t;

  localparam int unsigned STEP_DIR_SETUP_CYCLES  = 40;
  localparam int unsigned STEP_PULSE_HIGH_CYCLES = 20;

endpackage

// File: rtl/motor_step_generator_sync.sv
// Two-flop synchronizer for asynchronous motor pin inputs.
// Cleared by the synchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/motor_step_generator.sv
// Step/direction pulse generator for one motor: direction setup,
// fixed-width step pulses, end-switch stop and power-fail latch.
module motor_step_generator
  import MCPkg::*;
#(
  parameter int unsigned DIR_SETUP_CYCLES  = STEP_DIR_SETUP_CYCLES,
  parameter int unsigned PULSE_HIGH_CYCLES = STEP_PULSE_HIGH_CYCLES,
  parameter int unsigned MIN_PERIOD        = 2 * PULSE_HIGH_CYCLES
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_steps_ib16,
  input  logic        cmd_dir_i,
  input  logic [15:0] cmd_period_ib16,
  input  logic        cmd_boost_i,
  input  logic        enable_i,
  input  logic        abort_i,
  input  logic        fault_clr_i,
  input  logic        pl_pfail_i,
  input  logic        pl_sw_outa_i,
  input  logic        pl_sw_outb_i,
  output logic        pl_clk_o,
  output logic        pl_dir_o,
  output logic        pl_en_o,
  output logic        pl_boost_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] steps_done_ob16,
  output logic        limit_hit_o,
  output logic        fault_o
);

  localparam logic [15:0] SETUP_LD = 16'(DIR_SETUP_CYCLES - 1);
  localparam logic [15:0] HIGH_LD  = 16'(PULSE_HIGH_CYCLES - 1);
  localparam logic [15:0] HIGH_LEN = 16'(PULSE_HIGH_CYCLES);
  localparam logic [15:0] MIN_PER  = 16'(MIN_PERIOD);

  logic       clk;
  logic       rst_n;
  logic [2:0] async_w;
  logic [2:0] sync_w;
  logic       pf_s, swa_s, swb_s;

  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.reset;

  assign async_w = {pl_sw_outb_i, pl_sw_outa_i, pl_pfail_i};

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (async_w),
    .q_o    (sync_w)
  );

  assign {swb_s, swa_s, pf_s} = sync_w;

  stepgen_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] steps_q, steps_d;
  logic [15:0] period_q, period_d;
  logic [15:0] sdone_q, sdone_d;
  logic dir_q, dir_d;
  logic boost_q, boost_d;
  logic limit_q, limit_d;
  logic fault_q, fault_d;
  logic done_q, done_d;
  logic en_q, en_d;
  logic clk_q, clk_d;
  logic run_q, run_d;

  logic busy, accept, check, blocked;

  assign busy        = (state_q != IDLE);
  assign cmd_ready_o = run_q & enable_i & ~fault_q & ~busy;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign blocked     = dir_q ? swb_s : swa_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
    steps_d  = steps_q;
    period_d = period_q;
    sdone_d  = sdone_q;
    dir_d    = dir_q;
    boost_d  = boost_q;
    limit_d  = limit_q;
    done_d   = 1'b0;
    check    = 1'b0;
    run_d    = 1'b1;
    // Power fail and enable loss both abandon the move at once
    if (pf_s) begin
      state_d = IDLE;
      done_d  = busy | accept;
    end else if (busy && !enable_i) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sdone_d = '0;
            limit_d = 1'b0;
            if (cmd_steps_ib16 == '0) begin
              done_d = 1'b1;
            end else begin
              steps_d  = cmd_steps_ib16;
              dir_d    = cmd_dir_i;
              boost_d  = cmd_boost_i;
              period_d = (cmd_period_ib16 < MIN_PER) ?
                         MIN_PER : cmd_period_ib16;
              cnt_d    = SETUP_LD;
              state_d  = SETUP;
            end
          end
        end
        SETUP, LOW: check = (cnt_q == '0);
        HIGH: begin
          if (cnt_q == '0) begin
            state_d = LOW;
            cnt_d   = period_q - HIGH_LEN - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (check) begin
        if (blocked) begin
          state_d = IDLE;
          limit_d = 1'b1;
          done_d  = 1'b1;
        end else if (abort_i || sdone_q == steps_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = HIGH;
          cnt_d   = HIGH_LD;
          sdone_d = sdone_q + 16'd1;
        end
      end
    end
    if (pf_s)
      fault_d = 1'b1;
    else if (fault_clr_i)
      fault_d = 1'b0;
    else
      fault_d = fault_q;
    en_d  = enable_i & ~fault_d;
    clk_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      steps_q  <= '0;
      period_q <= '0;
      sdone_q  <= '0;
      dir_q    <= 1'b0;
      boost_q  <= 1'b0;
      limit_q  <= 1'b0;
      fault_q  <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      clk_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      period_q <= period_d;
      sdone_q  <= sdone_d;
      dir_q    <= dir_d;
      boost_q  <= boost_d;
      limit_q  <= limit_d;
      fault_q  <= fault_d;
      done_q   <= done_d;
      en_q     <= en_d;
      clk_q    <= clk_d;
      run_q    <= run_d;
    end
  end

  assign pl_clk_o        = clk_q;
  assign pl_dir_o        = dir_q;
  assign pl_en_o         = en_q;
  assign pl_boost_o      = boost_q & busy;
  assign busy_o          = busy;
  assign done_o          = done_q;
  assign steps_done_ob16 = sdone_q;
  assign limit_hit_o     = limit_q;
  assign fault_o         = fault_q;

endmodule

// File: tb/tb_motor_step_generator.sv
// Directed self-checking bench for motor_step_generator.
// Cycle indices count rising edges since time zero.
module tb_motor_step_generator;
  import MCPkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ckrs_t       ckrs;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_period = '0;
  logic        cmd_boost = 1'b0;
  logic        enable = 1'b1;
  logic        abort_s = 1'b0;
  logic        fault_clr = 1'b0;
  logic        pfail = 1'b0;
  logic        sw_a = 1'b0;
  logic        sw_b = 1'b0;
  logic        pl_clk, pl_dir, pl_en, pl_boost;
  logic        busy, done;
  logic [15:0] steps_done;
  logic        limit_hit, fault;

  assign ckrs.clk   = clk;
  assign ckrs.reset = rst_n;

  always #5 clk = ~clk;

  motor_step_generator dut (
    .ClkRs_ix        (ckrs),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_steps_ib16  (cmd_steps),
    .cmd_dir_i       (cmd_dir),
    .cmd_period_ib16 (cmd_period),
    .cmd_boost_i     (cmd_boost),
    .enable_i        (enable),
    .abort_i         (abort_s),
    .fault_clr_i     (fault_clr),
    .pl_pfail_i      (pfail),
    .pl_sw_outa_i    (sw_a),
    .pl_sw_outb_i    (sw_b),
    .pl_clk_o        (pl_clk),
    .pl_dir_o        (pl_dir),
    .pl_en_o         (pl_en),
    .pl_boost_o      (pl_boost),
    .busy_o          (busy),
    .done_o          (done),
    .steps_done_ob16 (steps_done),
    .limit_hit_o     (limit_hit),
    .fault_o         (fault)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rises[$];
  int   highs[$];
  int   dones[$];
  logic prev_clk = 1'b0;
  int   hi_start = 0;

  always @(negedge clk) begin
    if (pl_clk && !prev_clk) begin
      rises.push_back(cyc);
      hi_start <= cyc;
    end
    if (!pl_clk && prev_clk) highs.push_back(cyc - hi_start);
    if (done) dones.push_back(cyc);
    prev_clk <= pl_clk;
  end

  int total = 0;
  int passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int rz(input int i);
    return (i < rises.size()) ? rises[i] : -1;
  endfunction

  task automatic clear_log();
    rises.delete();
    highs.delete();
    dones.delete();
  endtask

  task automatic issue(input logic [15:0] st, input logic d,
                       input logic [15:0] per, input logic b,
                       output int c0);
    cmd_valid  = 1'b1;
    cmd_steps  = st;
    cmd_dir    = d;
    cmd_period = per;
    cmd_boost  = b;
    c0 = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n = 0;
    while (dones.size() == 0 && n < maxc) begin
      tick();
      n++;
    end
    tick();
    chk(tag, int'(dones.size() > 0), 1);
  endtask

  task automatic wait_rises(input int cnt, input int maxc,
                            input string tag);
    int n = 0;
    while (rises.size() < cnt && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, int'(rises.size() >= cnt), 1);
  endtask

  int c0;

  initial begin
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_clk", pl_clk, 0);
    chk("rst_en", pl_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", cmd_ready, 1);
    chk("rel_en", pl_en, 1);

    // three steps, period 100, dir 1, boost on
    clear_log();
    issue(16'd3, 1'b1, 16'd100, 1'b1, c0);
    chk("m1_dir", pl_dir, 1);
    chk("m1_busy", busy, 1);
    chk("m1_boost", pl_boost, 1);
    chk("m1_ready", cmd_ready, 0);
    wait_done(500, "m1_done_seen");
    chk("m1_nrise", rises.size(), 3);
    chk("m1_rise0", rz(0) - c0, 41);
    chk("m1_rise1", rz(1) - c0, 141);
    chk("m1_rise2", rz(2) - c0, 241);
    chk("m1_high", (highs.size() > 0) ? highs[0] : -1, 20);
    chk("m1_done_at", dones[0] - c0, 341);
    chk("m1_ndone", dones.size(), 1);
    chk("m1_steps", steps_done, 3);
    chk("m1_boost_off", pl_boost, 0);

    // zero-step command
    clear_log();
    issue(16'd0, 1'b0, 16'd100, 1'b0, c0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_steps", steps_done, 0);
    tick();
    chk("z_done_off", done, 0);
    chk("z_busy2", busy, 0);
    chk("z_norise", rises.size(), 0);

    // period below minimum
    clear_log();
    issue(16'd2, 1'b1, 16'd5, 1'b0, c0);
    wait_done(300, "p_done_seen");
    chk("p_nrise", rises.size(), 2);
    chk("p_spacing", rz(1) - rz(0), 40);
    chk("p_done_at", dones[0] - c0, 121);

    // end switch A stops a dir 0 move
    clear_log();
    issue(16'd10, 1'b0, 16'd100, 1'b0, c0);
    wait_rises(4, 600, "sw_rise4");
    sw_a = 1'b1;
    wait_done(600, "sw_done_seen");
    chk("sw_le5", int'(steps_done <= 16'd5), 1);
    chk("sw_limit", limit_hit, 1);
    chk("sw_busy", busy, 0);

    // switch A does not block dir 1
    clear_log();
    issue(16'd2, 1'b1, 16'd40, 1'b0, c0);
    chk("sw2_limit_clr", limit_hit, 0);
    wait_done(300, "sw2_done_seen");
    chk("sw2_steps", steps_done, 2);
    chk("sw2_limit", limit_hit, 0);
    sw_a = 1'b0;

    // abort stops at the next step check
    clear_log();
    issue(16'd5, 1'b1, 16'd40, 1'b0, c0);
    wait_rises(1, 100, "ab_rise1");
    abort_s = 1'b1;
    wait_done(200, "ab_done_seen");
    abort_s = 1'b0;
    chk("ab_steps", steps_done, 1);
    chk("ab_high", (highs.size() > 0) ? highs[0] : -1, 20);

    // power fail mid-pulse
    clear_log();
    issue(16'd5, 1'b1, 16'd100, 1'b0, c0);
    wait_rises(1, 100, "pf_rise1");
    pfail = 1'b1;
    repeat (3) tick();
    chk("pf_clk", pl_clk, 0);
    chk("pf_fault", fault, 1);
    chk("pf_en", pl_en, 0);
    chk("pf_ready", cmd_ready, 0);
    chk("pf_done", done, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick();
    chk("pf_clr_blocked", fault, 1);
    pfail = 1'b0;
    repeat (3) tick();
    chk("pf_still", fault, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("pf_cleared", fault, 0);
    chk("pf_en_back", pl_en, 1);
    chk("pf_ready_back", cmd_ready, 1);

    // reset pulse mid-move
    clear_log();
    issue(16'd3, 1'b1, 16'd100, 1'b1, c0);
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    chk("mr_clk", pl_clk, 0);
    chk("mr_dir", pl_dir, 0);
    chk("mr_en", pl_en, 0);
    chk("mr_boost", pl_boost, 0);
    chk("mr_busy", busy, 0);
    chk("mr_steps", steps_done, 0);
    chk("mr_ready", cmd_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("mr_ready_back", cmd_ready, 1);
    clear_log();
    issue(16'd1, 1'b1, 16'd40, 1'b0, c0);
    wait_done(200, "mr_done_seen");
    chk("mr_new_steps", steps_done, 1);
    chk("mr_new_rise", rz(0) - c0, 41);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
